// File: rtl/cdb_arbiter_if.sv
// Result-source and common-data-bus signal bundle for cdb_arbiter.
// Lane index 0=int, 1=mult, 2=div, 3=mem.
interface cdb_arbiter_if #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
);
  logic [3:0]             src_valid;
  logic [3:0][TAG_W-1:0]  src_tag;
  logic [3:0][DATA_W-1:0] src_data;
  logic [3:0]             src_ready;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [DATA_W-1:0]      cdb_data;

  modport master (
    output src_valid, src_tag, src_data,
    input  src_ready, cdb_valid, cdb_tag, cdb_data
  );
  modport slave (
    input  src_valid, src_tag, src_data,
    output src_ready, cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: four per-source result FIFOs drained one per cycle
// in round-robin order onto a registered broadcast bus.
module cdb_fifo #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              ready_o,
  output logic              empty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] data_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en, rd_en;

  // ready depends only on the count register, so a pop frees space next cycle
  assign ready_o = cnt_q < CNT_W'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign wr_en   = push_i & ready_o & ~flush_i;
  assign rd_en   = pop_i & ~empty_o & ~flush_i;
  assign tag_o   = mem_q[rd_ptr_q].tag;
  assign data_o  = mem_q[rd_ptr_q].data;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{tag: tag_i, data: data_i};
  end
endmodule

module cdb_arbiter #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  cdb_arbiter_if.slave  bus
);
  localparam int NUM_SRC = 4;

  logic [NUM_SRC-1:0]             empty, pop, rdy;
  logic [NUM_SRC-1:0][TAG_W-1:0]  head_tag;
  logic [NUM_SRC-1:0][DATA_W-1:0] head_data;
  logic [1:0]                     rr_q, rr_d, gnt_idx, idx;
  logic                           gnt_vld;
  logic                           vld_q, vld_d;
  logic [TAG_W-1:0]               tag_q, tag_d;
  logic [DATA_W-1:0]              data_q, data_d;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    cdb_fifo #(.TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (bus.src_valid[g]),
      .tag_i   (bus.src_tag[g]),
      .data_i  (bus.src_data[g]),
      .pop_i   (pop[g]),
      .ready_o (rdy[g]),
      .empty_o (empty[g]),
      .tag_o   (head_tag[g]),
      .data_o  (head_data[g])
    );
  end

  // First non-empty lane scanning upward from rr, wrapping 3->0
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_q;
    idx     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = rr_q + 2'(i);
      if (!gnt_vld && !empty[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    pop    = '0;
    rr_d   = rr_q;
    vld_d  = 1'b0;
    tag_d  = tag_q;
    data_d = data_q;
    if (flush_i) begin
      rr_d = '0;
    end else if (gnt_vld) begin
      pop[gnt_idx] = 1'b1;
      vld_d        = 1'b1;
      tag_d        = head_tag[gnt_idx];
      data_d       = head_data[gnt_idx];
      rr_d         = gnt_idx + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      vld_q  <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      rr_q   <= rr_d;
      vld_q  <= vld_d;
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign bus.src_ready = rdy;
  assign bus.cdb_valid = vld_q;
  assign bus.cdb_tag   = tag_q;
  assign bus.cdb_data  = data_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: constant vector table, directed corner sequences and
// random traffic, all scored against a queue-based reference of the bus rules.
module tb_cdb_arbiter;
  localparam int TAG_W = 6, DATA_W = 32, DEPTH = 2;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [DATA_W-1:0] dat_t;
  typedef struct { tag_t tag; dat_t data; } ent_t;
  typedef struct {
    logic fl; logic [3:0] v; logic [3:0][TAG_W-1:0] t; logic [3:0][DATA_W-1:0] d;
    logic ev; tag_t et; dat_t ed;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();
  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus));

  int   n_tests = 0, n_fail = 0;
  ent_t mq [4][$];
  logic mv; tag_t mt; dat_t md; int mrr;
  tag_t log_q [$];
  vec_t tbl [12];

  function automatic void model_reset();
    for (int s = 0; s < 4; s++) mq[s].delete();
    mv = 1'b0; mt = '0; md = '0; mrr = 0;
  endfunction

  // One rising edge of the bus rules, from the inputs currently driven
  function automatic void model_step();
    bit acc [4];
    ent_t e;
    for (int s = 0; s < 4; s++) acc[s] = bus.src_valid[s] && (mq[s].size() < DEPTH);
    if (flush) begin
      for (int s = 0; s < 4; s++) mq[s].delete();
      mv = 1'b0; mrr = 0;
      return;
    end
    mv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (mrr + k) % 4;
      if (!mv && mq[j].size() > 0) begin
        e = mq[j].pop_front();
        mv = 1'b1; mt = e.tag; md = e.data; mrr = (j + 1) % 4;
      end
    end
    for (int s = 0; s < 4; s++)
      if (acc[s]) mq[s].push_back('{tag: bus.src_tag[s], data: bus.src_data[s]});
  endfunction

  task automatic check_out(input string nm);
    logic [3:0] er;
    for (int s = 0; s < 4; s++) er[s] = mq[s].size() < DEPTH;
    n_tests++;
    if (bus.cdb_valid !== mv || bus.cdb_tag !== mt || bus.cdb_data !== md) begin
      n_fail++;
      $display("FAIL %s cdb: got v=%0b t=%0d d=%0d want v=%0b t=%0d d=%0d @%0t",
               nm, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, mv, mt, md, $time);
    end
    n_tests++;
    if (bus.src_ready !== er) begin
      n_fail++;
      $display("FAIL %s ready: got %b want %b @%0t", nm, bus.src_ready, er, $time);
    end
  endtask

  task automatic expect_true(input string nm, input bit ok, input int got, input int want);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d @%0t", nm, got, want, $time);
    end
  endtask

  task automatic tick(input string nm);
    model_step();
    @(posedge clk); #1;
    check_out(nm);
    if (bus.cdb_valid) log_q.push_back(bus.cdb_tag);
  endtask

  task automatic idle();
    bus.src_valid = '0; flush = 1'b0;
  endtask

  task automatic push(input int s, input int tag, input int data);
    bus.src_valid[s] = 1'b1;
    bus.src_tag[s]   = tag_t'(tag);
    bus.src_data[s]  = dat_t'(data);
  endtask

  function automatic vec_t mk(input int fl, input int v, input int t0, t1, t2, t3,
                              input int d0, d1, d2, d3, input int ev, et, ed);
    vec_t r;
    r.fl = fl[0]; r.v = v[3:0];
    r.t[0] = tag_t'(t0); r.t[1] = tag_t'(t1); r.t[2] = tag_t'(t2); r.t[3] = tag_t'(t3);
    r.d[0] = dat_t'(d0); r.d[1] = dat_t'(d1); r.d[2] = dat_t'(d2); r.d[3] = dat_t'(d3);
    r.ev = ev[0]; r.et = tag_t'(et); r.ed = dat_t'(ed);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit ok;
    tbl[0]  = mk(0, 4'b0001, 5, 0, 0, 0, 20, 0, 0, 0,    0, 0, 0);
    tbl[1]  = mk(0, 0,       0, 0, 0, 0, 0, 0, 0, 0,     1, 5, 20);
    tbl[2]  = mk(0, 0,       0, 0, 0, 0, 0, 0, 0, 0,     0, 5, 20);
    tbl[3]  = mk(1, 0,       0, 0, 0, 0, 0, 0, 0, 0,     0, 5, 20);
    tbl[4]  = mk(0, 4'b1111, 1, 2, 3, 4, 11, 22, 33, 44, 0, 5, 20);
    tbl[5]  = mk(0, 0,       0, 0, 0, 0, 0, 0, 0, 0,     1, 1, 11);
    tbl[6]  = mk(0, 0,       0, 0, 0, 0, 0, 0, 0, 0,     1, 2, 22);
    tbl[7]  = mk(0, 0,       0, 0, 0, 0, 0, 0, 0, 0,     1, 3, 33);
    tbl[8]  = mk(0, 0,       0, 0, 0, 0, 0, 0, 0, 0,     1, 4, 44);
    tbl[9]  = mk(0, 0,       0, 0, 0, 0, 0, 0, 0, 0,     0, 4, 44);
    tbl[10] = mk(0, 4'b0010, 0, 0, 0, 0, 0, 7, 0, 0,     0, 4, 44);
    tbl[11] = mk(0, 0,       0, 0, 0, 0, 0, 0, 0, 0,     1, 0, 7);

    bus.src_valid = '0; bus.src_tag = '0; bus.src_data = '0;
    model_reset();
    #12 check_out("reset");
    @(negedge clk); rst_n = 1'b1;

    // Table: single result, flush to rr=0, 4-way contention, tag 0
    foreach (tbl[i]) begin
      flush = tbl[i].fl; bus.src_valid = tbl[i].v;
      bus.src_tag = tbl[i].t; bus.src_data = tbl[i].d;
      tick("tbl");
      n_tests++;
      if (bus.cdb_valid !== tbl[i].ev || bus.cdb_tag !== tbl[i].et || bus.cdb_data !== tbl[i].ed) begin
        n_fail++;
        $display("FAIL vec%0d: got v=%0b t=%0d d=%0d want v=%0b t=%0d d=%0d", i,
                 bus.cdb_valid, bus.cdb_tag, bus.cdb_data, tbl[i].ev, tbl[i].et, tbl[i].ed);
      end
    end

    // Full div FIFO while the other three sources keep the bus busy
    idle(); flush = 1'b1; tick("flush0"); idle(); log_q.delete();
    push(0, 50, 500); push(1, 51, 510); push(2, 6, 600); push(3, 52, 520); tick("full1");
    push(0, 53, 530); push(1, 54, 540); push(2, 7, 700); push(3, 55, 550); tick("full2");
    expect_true("full_rdy2", bus.src_ready[2] === 1'b0, bus.src_ready[2], 0);
    push(0, 56, 560); push(1, 57, 570); push(2, 8, 800); push(3, 58, 580); tick("full3");
    expect_true("full_rdy3", bus.src_ready[2] === 1'b0, bus.src_ready[2], 0);
    bus.src_valid[2] = 1'b0; tick("full4");
    idle();
    for (int k = 0; k < 12; k++) tick("full_drain");
    begin
      tag_t dq [$];
      foreach (log_q[i]) if (log_q[i] inside {6, 7, 8}) dq.push_back(log_q[i]);
      ok = dq.size() == 2 && dq[0] == 6 && dq[1] == 7;
      expect_true("full_order", ok, dq.size(), 2);
    end

    // Fairness: int and mem stream every cycle
    flush = 1'b1; tick("flush1"); idle(); log_q.delete();
    for (int k = 0; k < 20; k++) begin
      push(0, k, k); push(3, 32 + k, 100 + k); tick("fair");
    end
    idle();
    for (int k = 0; k < 6; k++) tick("fair_drain");
    expect_true("fair_len", log_q.size() >= 16, log_q.size(), 16);
    if (log_q.size() >= 16) begin
      expect_true("fair_first", log_q[0] < 32, log_q[0], 0);
      for (int i = 1; i < 16; i++)
        expect_true("fair_alt", (log_q[i] < 32) != (log_q[i-1] < 32), log_q[i], log_q[i-1]);
    end

    // Flush with three results buffered
    flush = 1'b1; tick("flush2"); idle(); log_q.delete();
    push(0, 40, 1); push(1, 41, 2); push(2, 42, 3); tick("fl_push");
    idle(); flush = 1'b1; tick("fl_pulse"); flush = 1'b0;
    expect_true("flush_vld", bus.cdb_valid === 1'b0, bus.cdb_valid, 0);
    expect_true("flush_rdy", bus.src_ready === 4'hf, bus.src_ready, 15);
    for (int k = 0; k < 6; k++) tick("fl_idle");
    cnt = 0;
    foreach (log_q[i]) if (log_q[i] inside {40, 41, 42}) cnt++;
    expect_true("flush_gone", cnt == 0, cnt, 0);

    // Asynchronous reset mid-broadcast
    push(0, 3, 30); push(1, 4, 40); tick("rs_push"); idle(); tick("rs_bcast");
    expect_true("rs_pre", bus.cdb_valid === 1'b1, bus.cdb_valid, 1);
    #2 rst_n = 1'b0; #1;
    model_reset();
    expect_true("rst_async", bus.cdb_valid === 1'b0, bus.cdb_valid, 0);
    check_out("rst");
    push(0, 33, 330);
    @(posedge clk); #1 check_out("rst_hold");
    @(negedge clk); rst_n = 1'b1;
    push(0, 9, 126); tick("rst_push"); idle(); tick("rst_bcast");
    ok = bus.cdb_valid === 1'b1 && bus.cdb_tag === tag_t'(9) && bus.cdb_data === dat_t'(126);
    expect_true("rst_new", ok, bus.cdb_tag, 9);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      flush = ($urandom_range(0, 49) == 0);
      for (int s = 0; s < 4; s++) begin
        bus.src_valid[s] = ($urandom_range(0, 2) != 0);
        bus.src_tag[s]   = tag_t'($urandom);
        bus.src_data[s]  = $urandom;
      end
      tick("rand");
    end
    idle();
    for (int k = 0; k < 10; k++) tick("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter TAG_W, default 6, tag width on source ports and CDB.
REQ-002 Parameter DATA_W, default 32, data width on source ports and CDB.
REQ-003 Parameter DEPTH, default 2, entries per source FIFO; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous clear of all buffered results.
REQ-007 For each source s in {int, mult, div, mem}: s_valid  input  1  result offered.
REQ-008 For each s: s_tag  input  TAG_W  destination tag of the offered result.
REQ-009 For each s: s_data  input  DATA_W  result value.
REQ-010 For each s: s_ready  output  1  source FIFO can accept this cycle.
REQ-011 cdb_valid  output  1  CDB broadcast valid.
REQ-012 cdb_tag  output  TAG_W  CDB broadcast tag.
REQ-013 cdb_data  output  DATA_W  CDB broadcast data.

Function
REQ-014 Each source has its own DEPTH-entry FIFO holding {tag, data}.
REQ-015 s_ready SHALL equal (FIFO count < DEPTH), from registered state only, with no combinational path from any input.
REQ-016 A push occurs on a rising edge with s_valid & s_ready; with s_valid low, s_tag/s_data are ignored.
REQ-017 Per cycle, at most one FIFO is popped: the first non-empty FIFO in round-robin order starting at pointer rr (0=int,1=mult,2=div,3=mem), wrapping 3->0.
REQ-018 On a grant, cdb_valid<=1, cdb_tag/cdb_data <= the granted FIFO head, and rr <= (granted index + 1) mod 4.
REQ-019 With all FIFOs empty, cdb_valid<=0, rr holds, and cdb_tag/cdb_data hold their previous values.
REQ-020 Latency: a result pushed at edge N into an uncontended, empty FIFO appears on the CDB after edge N+1; there is no bypass around the FIFO.
REQ-021 A simultaneous push and pop on the same FIFO keeps its count unchanged and preserves FIFO order; a pop on a full FIFO raises s_ready in the following cycle, never the same cycle.
REQ-022 Results from one source are broadcast in acceptance order; nothing is dropped or duplicated.
REQ-023 Under sustained contention, each non-empty source is granted at least once every 4 cycles.
REQ-024 Tag value 0 carries no special meaning and is broadcast like any other tag.
REQ-025 flush=1 at an edge empties all FIFOs, sets cdb_valid<=0 and rr<=0, and ignores pushes and pops on that edge; flush has priority over all other updates.
REQ-026 FIFO pointer arithmetic wraps modulo DEPTH; count ranges 0..DEPTH.

Reset
REQ-027 rst low SHALL, asynchronously: empty all FIFOs, clear rr to 0, and clear cdb_valid, cdb_tag and cdb_data to 0.
REQ-028 While rst is low, all s_ready are 1 and no pushes are accepted.
REQ-029 Reset assertion mid-operation discards all buffered results; the first edge after deassertion behaves as after a cold reset.

Verification
REQ-030 Single: int pushes tag 5/data 20 at edge 1 -> after edge 2, cdb_valid=1, tag=5, data=20; after edge 3, cdb_valid=0.
REQ-031 Contention: all four sources push once on the same edge (tags 1,2,3,4) with rr=0 -> CDB shows tags 1,2,3,4 on four consecutive cycles, then cdb_valid=0.
REQ-032 Full: div pushes tags 6,7 back-to-back while blocked by a continuously busy higher-priority stream -> div_ready=0; no third push accepted; both tags later broadcast in order 6,7.
REQ-033 Fairness: int and mem stream continuously -> grants alternate int, mem, int, mem; rr never skips a non-empty source.
REQ-034 Flush: 3 results buffered, flush pulsed one cycle -> cdb_valid=0 from the next cycle, all s_ready=1, and none of the 3 tags ever appears.
REQ-035 Reset: rst driven low mid-broadcast -> cdb_valid=0 immediately, without waiting for a clock edge; after release, a new push of tag 9/data 126 appears after one edge.
